// File: rtl/riscv_pkg.sv
// Shared core definitions used by the fetch/decode boundary.
//   NOP_INSTR   : canonical bubble (addi x0, x0, 0)
//   fq_entry_t  : one fetch-queue slot, {pc, instr}
package riscv_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
   } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue between fetch and decode.
// Captures (PC, instr) pairs from fetch and presents the oldest one to decode,
// or a NOP bubble when empty. Back-pressures fetch when full and drops all
// entries on a redirect.
//   clk, rst             : clock, synchronous active-high reset
//   PC_F, Instr_F, Valid_F : fetched pair and its valid
//   Flush_D              : redirect, empties the queue on the next edge
//   Stall_D              : decode cannot take the head entry
//   Stall_F              : queue full, fetch must hold its PC
//   Valid_D, PC_D, Instr_D, PCPlus4_D : head entry as seen by decode
module fetch_queue
   import riscv_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned XLEN  = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] PC_F,
   input  logic [31:0]     Instr_F,
   input  logic            Valid_F,
   input  logic            Flush_D,
   input  logic            Stall_D,
   output logic            Stall_F,
   output logic            Valid_D,
   output logic [XLEN-1:0] PC_D,
   output logic [31:0]     Instr_D,
   output logic [XLEN-1:0] PCPlus4_D
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   fq_entry_t       mem [DEPTH];
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic [CW-1:0]   count;

   logic            full;
   logic            empty;
   logic            push;
   logic            pop;
   fq_entry_t       head;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   // Full is judged on registered count only, so a same-cycle pop never
   // lets a push in; this keeps Stall_D off the Stall_F path.
   assign push = Valid_F && !full && !Flush_D && !rst;
   assign pop  = !empty && !Stall_D && !Flush_D && !rst;

   always_ff @(posedge clk) begin
      if (rst || Flush_D) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end

   // Storage is never cleared; validity is carried by count alone.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr].pc    <= 64'(PC_F);
         mem[wr_ptr].instr <= Instr_F;
      end
   end

   assign head = mem[rd_ptr];

   always_comb begin
      Valid_D = !empty;
      Stall_F = full;
      PC_D    = '0;
      Instr_D = NOP_INSTR;
      if (!empty) begin
         PC_D    = head.pc[XLEN-1:0];
         Instr_D = head.instr;
      end
      PCPlus4_D = PC_D + XLEN'(4);
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed-vector bench for fetch_queue with hand-computed expectations.
module tb_fetch_queue;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned XLEN  = 64;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic            clk = 1'b0;
   logic            rst;
   logic [XLEN-1:0] PC_F;
   logic [31:0]     Instr_F;
   logic            Valid_F;
   logic            Flush_D;
   logic            Stall_D;
   logic            Stall_F;
   logic            Valid_D;
   logic [XLEN-1:0] PC_D;
   logic [31:0]     Instr_D;
   logic [XLEN-1:0] PCPlus4_D;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk       (clk),
      .rst       (rst),
      .PC_F      (PC_F),
      .Instr_F   (Instr_F),
      .Valid_F   (Valid_F),
      .Flush_D   (Flush_D),
      .Stall_D   (Stall_D),
      .Stall_F   (Stall_F),
      .Valid_D   (Valid_D),
      .PC_D      (PC_D),
      .Instr_D   (Instr_D),
      .PCPlus4_D (PCPlus4_D)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // One clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] ins);
      Valid_F = v;
      PC_F    = pc;
      Instr_F = ins;
   endtask

   task automatic chk_empty(input string tag);
      chk({tag, ".valid"}, 64'(Valid_D), 64'd0);
      chk({tag, ".pc"},    PC_D, 64'd0);
      chk({tag, ".instr"}, 64'(Instr_D), 64'(NOP));
      chk({tag, ".pc4"},   PCPlus4_D, 64'd4);
   endtask

   logic [31:0] stream_instr [3];

   initial begin
      stream_instr[0] = 32'h0050_0093;
      stream_instr[1] = 32'h00A0_0113;
      stream_instr[2] = 32'h0020_81B3;

      // Reset held two cycles with fetch offering a pair.
      rst = 1'b1; Flush_D = 1'b0; Stall_D = 1'b0;
      drive(1'b1, 64'h40, 32'h1111_1111);
      step(); step();
      chk_empty("reset");
      chk("reset.stall_f", 64'(Stall_F), 64'd0);
      rst = 1'b0;

      // Streaming: each pair appears the cycle after it is pushed.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 64'(4 * i), stream_instr[i]);
         step();
         chk($sformatf("stream%0d.pc", i), PC_D, 64'(4 * i));
         chk($sformatf("stream%0d.instr", i), 64'(Instr_D), 64'(stream_instr[i]));
         chk($sformatf("stream%0d.pc4", i), PCPlus4_D, 64'(4 * i + 4));
         chk($sformatf("stream%0d.count", i), 64'(dut.count), 64'd1);
      end
      drive(1'b0, 64'h0, 32'h0);
      step();
      chk_empty("drain");

      // Fill with decode stalled; fifth push is refused.
      Stall_D = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 64'h100 + 64'(4 * i), 32'h1000 + 32'(i));
         step();
         chk($sformatf("fill%0d.pc", i), PC_D, 64'h100);
         chk($sformatf("fill%0d.stall_f", i), 64'(Stall_F), (i >= 3) ? 64'd1 : 64'd0);
         chk($sformatf("fill%0d.count", i), 64'(dut.count), (i >= 3) ? 64'd4 : 64'(i + 1));
      end

      // Full: one pop with fetch still offering; the offer is refused.
      Stall_D = 1'b0;
      drive(1'b1, 64'h114, 32'h1005);
      step();
      chk("fullpp.pc", PC_D, 64'h104);
      chk("fullpp.instr", 64'(Instr_D), 64'h1001);
      chk("fullpp.count", 64'(dut.count), 64'd3);
      chk("fullpp.stall_f", 64'(Stall_F), 64'd0);

      // Flush beats stall and the simultaneous push.
      Stall_D = 1'b1; Flush_D = 1'b1;
      drive(1'b1, 64'h300, 32'h3333);
      step();
      chk_empty("flush");
      chk("flush.count", 64'(dut.count), 64'd0);
      Flush_D = 1'b0;
      drive(1'b1, 64'h200, 32'h2222);
      step();
      chk("postflush.pc", PC_D, 64'h200);
      chk("postflush.instr", 64'(Instr_D), 64'h2222);
      chk("postflush.valid", 64'(Valid_D), 64'd1);

      // Drain, then stream ten pairs through the wrapping pointers.
      Stall_D = 1'b0;
      drive(1'b0, 64'h0, 32'h0);
      step();
      chk("predrain.valid", 64'(Valid_D), 64'd0);
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 64'h400 + 64'(4 * i), 32'hA000 + 32'(i));
         step();
         chk($sformatf("wrap%0d.pc", i), PC_D, 64'h400 + 64'(4 * i));
         chk($sformatf("wrap%0d.instr", i), 64'(Instr_D), 64'hA000 + 64'(i));
      end

      // PC+4 wraps modulo 2^XLEN.
      drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'hBEEF);
      step();
      chk("ovf.pc", PC_D, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("ovf.pc4", PCPlus4_D, 64'd0);

      // Reset mid-operation drops queued entries.
      Stall_D = 1'b1;
      drive(1'b1, 64'h500, 32'h5555);
      step();
      chk("midrst.pre_count", 64'(dut.count), 64'd2);
      rst = 1'b1;
      step();
      chk_empty("midrst");
      chk("midrst.count", 64'(dut.count), 64'd0);
      rst = 1'b0;
      drive(1'b0, 64'h0, 32'h0);
      step();
      chk("midrst.after", 64'(Valid_D), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction queue between the fetch stage and decode. Captures each fetched (PC, instruction) pair into a small circular FIFO. Presents the oldest entry to decode, or a NOP bubble when empty. Back-pressures fetch through `Stall_F` when full, and discards all in-flight instructions on a taken branch or jump from Execute. This decouples decode stalls from the PC register and keeps a one-cycle fetch→decode latency.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; power of two, ≥2
- `XLEN`, 64: PC width

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `PC_F`  in  XLEN  PC of the instruction being fetched
- `Instr_F`  in  32  raw instruction read at `PC_F`
- `Valid_F`  in  1  fetch presents a valid pair this cycle
- `Flush_D`  in  1  redirect; driven by `PCSrc_E`; empties the queue
- `Stall_D`  in  1  decode cannot accept the head entry this cycle
- `Stall_F`  out  1  queue full; fetch must hold its PC
- `Valid_D`  out  1  head entry is valid
- `PC_D`  out  XLEN  PC of the head entry; 0 when empty
- `Instr_D`  out  32  head instruction; `NOP_INSTR` (0x00000013) when empty
- `PCPlus4_D`  out  XLEN  `PC_D + 4`, modulo 2^XLEN; 4 when empty

## Operation
- State: `DEPTH` entries of {PC, instr}, plus head pointer `rd_ptr`, tail pointer `wr_ptr` (each `$clog2(DEPTH)` bits), and `count` (`$clog2(DEPTH+1)` bits).
- Pointers wrap naturally modulo `DEPTH`; no special case at the top entry.
- `push = Valid_F && (count != DEPTH) && !Flush_D`. On push, write {`PC_F`, `Instr_F`} at `wr_ptr` and increment `wr_ptr`.
- `pop = (count != 0) && !Stall_D && !Flush_D`. On pop, increment `rd_ptr`.
- Count update: +1 on push only, −1 on pop only, unchanged when both or neither occur.
- Push while full is refused even if a pop occurs the same cycle. `Stall_F` depends only on registered `count`, so there is no combinational path from `Stall_D` to `Stall_F`.
- Pop and push in the same cycle on a non-empty, non-full queue: both take effect.
- `Stall_F = (count == DEPTH)`.
- `Valid_D = (count != 0)`.
- `PC_D`/`Instr_D` are read combinationally from the entry at `rd_ptr`. They are forced to 0/`NOP_INSTR` when empty.
- Flush: next edge sets `count`, `rd_ptr` and `wr_ptr` to 0. Any simultaneous push or pop is discarded. Stored data is not cleared.
- Flush and `Stall_D` together: flush wins.
- Flush and `rst` together: identical result.
- Reset: same clearing as flush. Outputs after reset:
  - `Valid_D`=0, `Stall_F`=0
  - `PC_D`=0, `Instr_D`=0x00000013, `PCPlus4_D`=4
- Reset asserted mid-operation discards all entries on that edge. Inputs in the reset cycle are ignored.

## Timing
- Fetch→decode latency: an entry pushed at edge N is visible on the `_D` outputs after edge N, assuming the queue was empty.
- Throughput: one instruction per cycle when `Stall_D`=0 and fetch is continuous. `count` then stays at 1.
- Full assertion: `Stall_F` rises the cycle after the push that fills the queue. It falls the cycle after the first pop.
- Redirect: the queue is empty the cycle after `Flush_D`. The first target instruction reaches decode one cycle later, i.e. a 2-cycle bubble counted from `PCSrc_E`.

## Structure
- Shared package `riscv_pkg` holds:
  - `localparam logic [31:0] NOP_INSTR = 32'h0000_0013`
  - `typedef struct packed { logic [63:0] pc; logic [31:0] instr; } fq_entry_t`
- Storage is a single `fq_entry_t` array in this module, with no sub-module. Pointer and count logic is small enough to stay inline.
- Instantiated at the top level between `fetch` and the decode stage.
- `Stall_F` is ORed with the hazard unit's stall before driving fetch.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `Valid_F`=1 -> `Valid_D`=0, `Instr_D`=0x00000013, `PC_D`=0, `PCPlus4_D`=4, `Stall_F`=0.
- Streaming: push PCs 0x0, 0x4, 0x8 with instrs 0x00500093, 0x00A00113, 0x002081B3 and `Stall_D`=0 -> decode sees them one cycle each, in order, and `count` never exceeds 1.
- Fill: `Stall_D`=1 and 5 pushes at PCs 0x100–0x110 -> `Stall_F`=1 after the 4th push, the 5th push (0x110) is refused, and `PC_D`=0x100 throughout.
- Full push+pop: on the full queue, release `Stall_D` for 1 cycle with `Valid_F`=1 -> head advances to 0x104, `count`=3, the offered entry is not written, and `Stall_F` falls.
- Flush: queue holding 3 entries, assert `Flush_D` with `Valid_F`=1 and `Stall_D`=1 -> next cycle `Valid_D`=0 and `count`=0. A push of PC 0x200 the following cycle appears at `PC_D`=0x200.
- Wrap and overflow: 10 push/pop pairs through `DEPTH`=4 -> order preserved across pointer wrap. Pushing PC 0xFFFF_FFFF_FFFF_FFFC -> `PCPlus4_D`=0.
